// File: rtl/instr_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage: FSM state
// type, the opcodes the fetcher needs to recognise, and a small helper.
package instr_fetch_pkg;

    // Fetch FSM states
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ISSUE   = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_VALID   = 3'd3,
        ST_HALTED  = 3'd4
    } fetch_state_e;

    // Opcodes relevant to fetching (the rest are opaque bytes here)
    localparam logic [7:0] OP_ENDOP = 8'd25;
    localparam logic [7:0] OP_NOP   = 8'd26;

    // True in the states where a fetch is in progress and a jump is honoured
    function automatic logic fetch_active(input fetch_state_e st);
        logic active_s;
        case (st)
            ST_ISSUE,
            ST_CAPTURE,
            ST_VALID:  active_s = 1'b1;
            default:   active_s = 1'b0;
        endcase
        return active_s;
    endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Bundle of the fetch stage's control-unit handshake and instr_mem read port.
// master = the fetch stage, slave = its environment (control unit + memory).
interface instr_fetch_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
);
    logic                  start;
    logic                  ir_ack;
    logic                  pc_load;
    logic [ADDR_WIDTH-1:0] pc_load_val;
    logic [ADDR_WIDTH-1:0] mem_r_addr;
    logic [DATA_WIDTH-1:0] mem_r_instr;
    logic [DATA_WIDTH-1:0] ir;
    logic                  ir_valid;
    logic [ADDR_WIDTH-1:0] pc;
    logic                  halted;

    modport master (
        input  start, ir_ack, pc_load, pc_load_val, mem_r_instr,
        output mem_r_addr, ir, ir_valid, pc, halted
    );

    modport slave (
        output start, ir_ack, pc_load, pc_load_val, mem_r_instr,
        input  mem_r_addr, ir, ir_valid, pc, halted
    );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, drives instr_mem's read address,
// absorbs the memory's one-cycle read latency, and presents each fetched
// byte in IR with a valid/ack handshake. Supports jumps and halt on ENDOP.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    ADDR_WIDTH = 8,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = {ADDR_WIDTH{1'b0}},
    parameter logic [DATA_WIDTH-1:0] ENDOP_CODE = DATA_WIDTH'(OP_ENDOP)
) (
    input  logic           clk,
    input  logic           rst_n,
    instr_fetch_if.master  bus
);

    localparam logic [ADDR_WIDTH-1:0] PC_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    fetch_state_e          state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [DATA_WIDTH-1:0] ir_q, ir_d;
    logic                  ir_valid_q, ir_valid_d;
    logic                  halted_q, halted_d;
    logic                  jump_s;
    logic                  is_endop_s;

    // A jump is only meaningful while a fetch is in progress
    assign jump_s     = bus.pc_load & fetch_active(state_q);
    assign is_endop_s = (ir_q == ENDOP_CODE);

    // State register; reset aborts any in-flight read
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: ISSUE -> CAPTURE -> VALID per byte, jumps restart at ISSUE
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) state_d = ST_ISSUE;
                else           state_d = ST_IDLE;
            end
            ST_ISSUE: begin
                if (jump_s) state_d = ST_ISSUE;
                else        state_d = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                if (jump_s) state_d = ST_ISSUE;
                else        state_d = ST_VALID;
            end
            ST_VALID: begin
                if (jump_s)          state_d = ST_ISSUE;
                else if (!bus.ir_ack) state_d = ST_VALID;
                else if (is_endop_s) state_d = ST_HALTED;
                else                 state_d = ST_ISSUE;
            end
            ST_HALTED: begin
                if (bus.start) state_d = ST_ISSUE;
                else           state_d = ST_HALTED;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath next values: PC, IR, valid flag and halt flag per state
    always_comb begin
        pc_d       = pc_q;
        ir_d       = ir_q;
        ir_valid_d = ir_valid_q;
        halted_d   = halted_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) pc_d = RESET_PC;
                else           pc_d = pc_q;
            end
            ST_ISSUE: begin
                if (jump_s) pc_d = bus.pc_load_val;
                else        pc_d = pc_q;
            end
            ST_CAPTURE: begin
                // A jump here discards the byte arriving from memory
                if (jump_s) begin
                    pc_d = bus.pc_load_val;
                end else begin
                    ir_d       = bus.mem_r_instr;
                    ir_valid_d = 1'b1;
                    pc_d       = pc_q + PC_ONE;
                end
            end
            ST_VALID: begin
                // Jump implies ack and overrides the ENDOP halt check
                if (jump_s) begin
                    pc_d       = bus.pc_load_val;
                    ir_valid_d = 1'b0;
                end else if (bus.ir_ack) begin
                    ir_valid_d = 1'b0;
                    if (is_endop_s) halted_d = 1'b1;
                    else            halted_d = 1'b0;
                end else begin
                    ir_valid_d = 1'b1;
                end
            end
            ST_HALTED: begin
                if (bus.start) begin
                    pc_d     = RESET_PC;
                    halted_d = 1'b0;
                end else begin
                    halted_d = 1'b1;
                end
            end
            default: begin
                pc_d       = RESET_PC;
                ir_valid_d = 1'b0;
                halted_d   = 1'b0;
            end
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q       <= RESET_PC;
            ir_q       <= {DATA_WIDTH{1'b0}};
            ir_valid_q <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            ir_valid_q <= ir_valid_d;
            halted_q   <= halted_d;
        end
    end

    // Outputs come straight from flops; the memory address is the PC itself
    assign bus.mem_r_addr = pc_q;
    assign bus.pc         = pc_q;
    assign bus.ir         = ir_q;
    assign bus.ir_valid   = ir_valid_q;
    assign bus.halted     = halted_q;

endmodule
